// File: rtl/mul_arb.sv
// Two-requester round-robin arbiter in front of a shared pipelined multiplier.
// Tracks issued ops with a tag pipe and buffers each requester's product until it is accepted.
module mul_arb #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned LAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Flush,
  input  logic [1:0]          ReqValid,
  output logic [1:0]          ReqReady,
  input  logic [XLEN-1:0]     ReqSrcA0,
  input  logic [XLEN-1:0]     ReqSrcB0,
  input  logic [XLEN-1:0]     ReqSrcA1,
  input  logic [XLEN-1:0]     ReqSrcB1,
  input  logic [2:0]          ReqFunct3_0,
  input  logic [2:0]          ReqFunct3_1,
  output logic [1:0]          RspValid,
  input  logic [1:0]          RspReady,
  output logic [2*XLEN-1:0]   RspProd0,
  output logic [2*XLEN-1:0]   RspProd1,
  output logic [XLEN-1:0]     MulSrcA,
  output logic [XLEN-1:0]     MulSrcB,
  output logic [2:0]          MulFunct3,
  output logic                MulIssue,
  input  logic [2*XLEN-1:0]   MulProd
);

  logic [LAT-1:0] tag_valid;
  logic [LAT-1:0] tag_id;
  logic           last_gnt;
  logic [1:0]     busy;
  logic [1:0]     elig;
  logic [1:0]     grant;
  logic [1:0]     cap_hit;

  // A requester is busy from issue until its buffered product is consumed
  always_comb begin
    busy = RspValid;
    for (int unsigned i = 0; i < LAT; i++) begin
      if (tag_valid[i]) busy[tag_id[i]] = 1'b1;
    end
  end

  assign elig = ReqValid & ~busy & {2{~(Flush | reset)}};

  // Round-robin: on contention, favour the requester not granted last
  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b11:   grant = last_gnt ? 2'b01 : 2'b10;
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    ReqReady  = grant;
    MulIssue  = |grant;
    MulSrcA   = '0;
    MulSrcB   = '0;
    MulFunct3 = 3'b000;
    if (grant[0]) begin
      MulSrcA   = ReqSrcA0;
      MulSrcB   = ReqSrcB0;
      MulFunct3 = ReqFunct3_0;
    end else if (grant[1]) begin
      MulSrcA   = ReqSrcA1;
      MulSrcB   = ReqSrcB1;
      MulFunct3 = ReqFunct3_1;
    end
  end

  // Tag pipe mirrors the multiplier latency; it never stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_id[0] <= grant[1];
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_id[i] <= tag_id[i-1];
      end
      if (Flush) begin
        tag_valid <= '0;
      end else begin
        tag_valid[0] <= MulIssue;
        for (int unsigned i = 1; i < LAT; i++) begin
          tag_valid[i] <= tag_valid[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (MulIssue) begin
      last_gnt <= grant[1];
    end
  end

  assign cap_hit = {2{tag_valid[LAT-1] & ~Flush}} & {tag_id[LAT-1], ~tag_id[LAT-1]};

  // Response buffers: capture from the tag pipe tail, clear on accept or flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RspValid <= 2'b00;
      RspProd0 <= '0;
      RspProd1 <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (Flush)           RspValid[i] <= 1'b0;
        else if (cap_hit[i]) RspValid[i] <= 1'b1;
        else if (RspReady[i]) RspValid[i] <= 1'b0;
      end
      if (cap_hit[0]) RspProd0 <= MulProd;
      if (cap_hit[1]) RspProd1 <= MulProd;
    end
  end

endmodule
